div_fx_signed: RTL and testbench

//   Signed fixed-point iterative divider (radix-2, one quotient bit per cycle) with

---
 rtl/div_fx_signed.sv | 226 ++++++++++++++++++++++
 tb/tb_div_fx_signed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_fx_signed.sv
// div_fx_signed: signed fixed-point iterative divider, q = x / y in Q(WIDTH-FBITS).FBITS.
//
// The divider is radix-2 restoring and produces one quotient bit per clock. Both
// sides use valid/ready handshakes. The result can optionally be rounded half away
// from zero and saturates on overflow.
//
// Ports
//   clk        clock, all logic on posedge
//   rst        synchronous reset, active high
//   in_valid   x/y valid; transfer on in_valid && in_ready
//   in_ready   high only when idle and not in reset
//   x, y       dividend / divisor, signed fixed point
//   out_valid  q/r/dbz/ovf valid; held until out_ready
//   out_ready  consumer accepts result on out_valid && out_ready
//   q          quotient, signed fixed point (saturated when ovf)
//   r          remainder of the truncated quotient, carries the sign of x
//   dbz        divide by zero (y == 0)
//   ovf        quotient not representable; q saturated
//
// Timing
//   Flow is Idle -> Calc (ITER cycles) -> Fix -> Done.
//   out_valid is first seen ITER+2 edges after the accept edge. For y == 0 it is
//   seen after 1 edge.
module div_fx_signed #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FBITS = 4,
  parameter int unsigned ROUND = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf
);

  // Iteration counts: the truncated quotient needs WIDTH+FBITS bits, and rounding
  // adds one guard bit below that.
  localparam int unsigned Iter      = WIDTH + FBITS + ROUND;
  localparam int unsigned TruncIter = WIDTH + FBITS;
  localparam int unsigned CntW      = $clog2(Iter + 1);
  localparam int unsigned AccW      = WIDTH + 1;
  // One spare bit so the rounding increment cannot wrap.
  localparam int unsigned MW        = Iter + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [Iter-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]  ay_q, ay_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              sx_q, sx_d;
  logic              xs_q, xs_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  // Combinational helpers
  logic [WIDTH-1:0]  ax, ay;
  logic [Iter-1:0]   dvd;
  logic [AccW:0]     trial;
  logic              qbit;
  logic [MW-1:0]     m;
  logic [MW-1:0]     lim;

  // Magnitudes as unsigned WIDTH-bit values. The most negative operand maps to
  // 2^(WIDTH-1) exactly, which still fits.
  assign ax = x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  assign ay = y[WIDTH-1] ? (~y + WIDTH'(1)) : y;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    quo_d       = quo_q;
    ay_d        = ay_q;
    rem_d       = rem_q;
    sx_d        = sx_q;
    xs_d        = xs_q;
    out_valid_d = out_valid_q;
    q_d         = q_q;
    r_d         = r_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    dvd         = '0;
    trial       = '0;
    qbit        = 1'b0;
    m           = '0;
    lim         = '0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sx_d = x[WIDTH-1] ^ y[WIDTH-1];
          xs_d = x[WIDTH-1];
          ay_d = ay;
          if (y == '0) begin
            q_d         = '0;
            r_d         = '0;
            dbz_d       = 1'b1;
            ovf_d       = 1'b0;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            // The quotient register starts out holding the scaled dividend.
            // Dividend bits shift out of its top while quotient bits shift
            // in at the bottom.
            dvd[WIDTH-1:0] = ax;
            dvd            = dvd << (FBITS + ROUND);
            quo_d          = dvd;
            acc_d          = '0;
            cnt_d          = '0;
            state_d        = StCalc;
          end
        end
      end

      StCalc: begin
        trial = {acc_q, quo_q[Iter-1]};
        if (trial >= {2'b00, ay_q}) begin
          acc_d = AccW'(trial - {2'b00, ay_q});
          qbit  = 1'b1;
        end else begin
          acc_d = AccW'(trial);
          qbit  = 1'b0;
        end
        quo_d = {quo_q[Iter-2:0], qbit};
        // The remainder belongs to the truncated quotient, so capture it before
        // the guard iteration when rounding.
        if (cnt_q == CntW'(TruncIter - 1)) begin
          rem_d = acc_d[WIDTH-1:0];
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(Iter - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        m = {1'b0, quo_q} >> ROUND;
        if (ROUND != 0) begin
          // The guard bit set means a fraction of at least one half, so bump the
          // magnitude. That is half away from zero once the sign is applied.
          m = m + MW'(quo_q[0]);
        end
        // Negative results may reach 2^(WIDTH-1); positive ones stop one short.
        lim = MW'(1) << (WIDTH - 1);
        if (!sx_q) begin
          lim = lim - MW'(1);
        end
        if (m > lim) begin
          ovf_d = 1'b1;
          q_d   = sx_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
          ovf_d = 1'b0;
          q_d   = sx_q ? (~m[WIDTH-1:0] + WIDTH'(1)) : m[WIDTH-1:0];
        end
        r_d         = xs_q ? (~rem_q + WIDTH'(1)) : rem_q;
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = StDone;
      end

      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      acc_q       <= '0;
      quo_q       <= '0;
      ay_q        <= '0;
      rem_q       <= '0;
      sx_q        <= 1'b0;
      xs_q        <= 1'b0;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      quo_q       <= quo_d;
      ay_q        <= ay_d;
      rem_q       <= rem_d;
      sx_q        <= sx_d;
      xs_q        <= xs_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      r_q         <= r_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_fx_signed.sv
// Testbench for div_fx_signed (WIDTH=8, FBITS=4).
// Instance u_dut0 uses truncation (ROUND=0) and u_dut1 uses rounding (ROUND=1).
// A vector table covers both instances. Hand-written sequences cover
// back-pressure and reset in the middle of a calculation.
module tb_div_fx_signed;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic       sel;
  logic [7:0] x, y;
  logic       out_ready;

  logic       in_valid0, in_ready0, out_valid0, dbz0, ovf0;
  logic [7:0] q0, r0;
  logic       in_valid1, in_ready1, out_valid1, dbz1, ovf1;
  logic [7:0] q1, r1;

  logic       cur_ir, cur_ov, cur_dbz, cur_ovf;
  logic [7:0] cur_q, cur_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign in_valid0 = iv & ~sel;
  assign in_valid1 = iv & sel;

  assign cur_ir  = sel ? in_ready1  : in_ready0;
  assign cur_ov  = sel ? out_valid1 : out_valid0;
  assign cur_q   = sel ? q1 : q0;
  assign cur_r   = sel ? r1 : r0;
  assign cur_dbz = sel ? dbz1 : dbz0;
  assign cur_ovf = sel ? ovf1 : ovf0;

  div_fx_signed #(.WIDTH(8), .FBITS(4), .ROUND(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .x         (x),
    .y         (y),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .q         (q0),
    .r         (r0),
    .dbz       (dbz0),
    .ovf       (ovf0)
  );

  div_fx_signed #(.WIDTH(8), .FBITS(4), .ROUND(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .x         (x),
    .y         (y),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .q         (q1),
    .r         (r1),
    .dbz       (dbz1),
    .ovf       (ovf1)
  );

  typedef struct {
    logic       rnd;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Offer one operation to the selected instance. Return the number of edges from
  // the accept edge up to the edge where the result can be handed off.
  task automatic do_op(input logic s, input logic [7:0] xi, input logic [7:0] yi,
                       output int lat);
    int guard;
    sel   = s;
    x     = xi;
    y     = yi;
    iv    = 1'b1;
    guard = 0;
    while (!cur_ir && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    iv = 1'b0;
    // Operands only need to be valid at the transfer edge.
    x   = 8'hA5;
    y   = 8'h5A;
    lat = 1;
    while (!cur_ov && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  seen;
    string tag;

    rst       = 1'b1;
    iv        = 1'b0;
    sel       = 1'b0;
    x         = 8'h00;
    y         = 8'h00;
    out_ready = 1'b1;

    //            rnd   x      y      q      r      dbz   ovf   lat
    vecs.push_back('{1'b0, 8'h30, 8'h20, 8'h18, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'hD0, 8'h20, 8'hE8, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h20, 8'h30, 8'h0A, 8'h20, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h70, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b1, 14});
    vecs.push_back('{1'b0, 8'h80, 8'hF0, 8'h7F, 8'h00, 1'b0, 1'b1, 14});
    vecs.push_back('{1'b0, 8'h80, 8'h10, 8'h80, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h55, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1});
    vecs.push_back('{1'b0, 8'hE0, 8'h30, 8'hF6, 8'hE0, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h13, 8'hF9, 8'hD5, 8'h03, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h00, 8'h35, 8'h00, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h80, 8'h80, 8'h10, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b0, 8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 14});
    vecs.push_back('{1'b0, 8'h81, 8'h7F, 8'hF0, 8'h00, 1'b0, 1'b0, 14});
    vecs.push_back('{1'b1, 8'h20, 8'h30, 8'h0B, 8'h20, 1'b0, 1'b0, 15});
    vecs.push_back('{1'b1, 8'hE0, 8'h30, 8'hF5, 8'hE0, 1'b0, 1'b0, 15});
    vecs.push_back('{1'b1, 8'h13, 8'hF9, 8'hD5, 8'h03, 1'b0, 1'b0, 15});
    vecs.push_back('{1'b1, 8'h80, 8'h10, 8'h80, 8'h00, 1'b0, 1'b0, 15});
    vecs.push_back('{1'b1, 8'h7F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 15});
    vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready0", {31'd0, in_ready0}, 32'd0);
    check("rst in_ready1", {31'd0, in_ready1}, 32'd0);
    check("rst out_valid0", {31'd0, out_valid0}, 32'd0);
    check("rst q0", {24'd0, q0}, 32'd0);
    check("rst r0", {24'd0, r0}, 32'd0);
    check("rst dbz0", {31'd0, dbz0}, 32'd0);
    check("rst ovf0", {31'd0, ovf0}, 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready0", {31'd0, in_ready0}, 32'd1);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("v%0d(%h/%h r%0d)", i, vecs[i].x, vecs[i].y, vecs[i].rnd);
      do_op(vecs[i].rnd, vecs[i].x, vecs[i].y, lat);
      check({tag, " lat"}, lat, vecs[i].lat);
      check({tag, " q"}, {24'd0, cur_q}, {24'd0, vecs[i].q});
      check({tag, " r"}, {24'd0, cur_r}, {24'd0, vecs[i].r});
      check({tag, " dbz"}, {31'd0, cur_dbz}, {31'd0, vecs[i].dbz});
      check({tag, " ovf"}, {31'd0, cur_ovf}, {31'd0, vecs[i].ovf});
      @(posedge clk); #1;
      check({tag, " out_valid drop"}, {31'd0, cur_ov}, 32'd0);
      check({tag, " in_ready back"}, {31'd0, cur_ir}, 32'd1);
    end

    // Back-pressure: hold the result for 5 clocks with a competing input offered
    out_ready = 1'b0;
    do_op(1'b0, 8'h30, 8'h20, lat);
    check("bp lat", lat, 14);
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1;
      x  = 8'h10;
      y  = 8'h10;
      check($sformatf("bp q c%0d", k), {24'd0, q0}, 32'h18);
      check($sformatf("bp r c%0d", k), {24'd0, r0}, 32'h00);
      check($sformatf("bp out_valid c%0d", k), {31'd0, out_valid0}, 32'd1);
      check($sformatf("bp in_ready c%0d", k), {31'd0, in_ready0}, 32'd0);
      @(posedge clk); #1;
    end
    iv        = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp out_valid after pulse", {31'd0, out_valid0}, 32'd0);
    check("bp in_ready after pulse", {31'd0, in_ready0}, 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1'b1;
    end
    check("bp no stray result", {31'd0, seen}, 32'd0);

    // Reset in the middle of a calculation
    sel = 1'b0;
    x   = 8'h70;
    y   = 8'h08;
    iv  = 1'b1;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst busy in_ready", {31'd0, in_ready0}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst in_ready during rst", {31'd0, in_ready0}, 32'd0);
    check("midrst q cleared", {24'd0, q0}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst in_ready after rst", {31'd0, in_ready0}, 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid0) seen = 1'b1;
    end
    check("midrst no out_valid", {31'd0, seen}, 32'd0);
    do_op(1'b0, 8'h30, 8'h20, lat);
    check("midrst next lat", lat, 14);
    check("midrst next q", {24'd0, q0}, 32'h18);
    check("midrst next ovf", {31'd0, ovf0}, 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
